// File: rtl/ras_ckpt.sv
// Return-address stack with in-order checkpoint FIFO for misprediction rollback.
// Optional macro RAS_CKPT_TOP_SAVE_EN: checkpoints also save/repair the top entry.
module ras_ckpt #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int ADDR      = 4,
  parameter int CKPTS     = 4,
  parameter int CKPT_ADDR = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout,
  output logic                 pop_valid,
  output logic                 empty,
  output logic                 full,
  output logic [ADDR:0]        count,
  input  logic                 ckpt,
  output logic                 ckpt_ready,
  output logic [CKPT_ADDR-1:0] ckpt_tag,
  input  logic                 restore,
  input  logic [CKPT_ADDR-1:0] restore_tag,
  input  logic                 ckpt_release
);

  localparam logic [ADDR:0]      FULL_CNT = (ADDR+1)'(DEPTH);
  localparam logic [CKPT_ADDR:0] OCC_MAX  = (CKPT_ADDR+1)'(CKPTS);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR-1:0]      slot_tos [CKPTS];
  logic [ADDR:0]        slot_cnt [CKPTS];
`ifdef RAS_CKPT_TOP_SAVE_EN
  logic [WIDTH-1:0]     slot_top [CKPTS];
  logic [WIDTH-1:0]     top_save;
`endif

  logic [ADDR-1:0]      tos_reg, tos_next;
  logic [ADDR:0]        count_reg, count_next;
  logic [CKPT_ADDR-1:0] wr_reg, wr_next, rd_reg, rd_next;
  logic [CKPT_ADDR:0]   occ_reg, occ_next;
  logic [CKPT_ADDR-1:0] restore_off;
  logic                 restore_hit;
  logic                 do_ckpt, do_rel;
  logic                 mem_we;
  logic [ADDR-1:0]      mem_waddr;
  logic [WIDTH-1:0]     mem_wdata;

  assign dout       = mem[tos_reg];
  assign empty      = (count_reg == '0);
  assign full       = (count_reg == FULL_CNT);
  assign count      = count_reg;
  assign pop_valid  = pop && !empty;
  assign ckpt_ready = (occ_reg != OCC_MAX);
  assign ckpt_tag   = wr_reg;

  // A tag is live when its distance from the oldest slot is below occupancy.
  assign restore_off = restore_tag - rd_reg;
  assign restore_hit = restore && ({1'b0, restore_off} < occ_reg);

  always_comb begin
    tos_next   = tos_reg;
    count_next = count_reg;
    wr_next    = wr_reg;
    rd_next    = rd_reg;
    occ_next   = occ_reg;
    mem_we     = 1'b0;
    mem_waddr  = tos_reg;
    mem_wdata  = din;
    do_ckpt    = 1'b0;
    do_rel     = 1'b0;

    if (restore) begin
      if (restore_hit) begin
        tos_next   = slot_tos[restore_tag];
        count_next = slot_cnt[restore_tag];
        wr_next    = restore_tag;
        occ_next   = {1'b0, restore_off};
`ifdef RAS_CKPT_TOP_SAVE_EN
        mem_we     = 1'b1;
        mem_waddr  = slot_tos[restore_tag];
        mem_wdata  = slot_top[restore_tag];
`endif
      end
    end else begin
      if (push && pop && !empty) begin
        mem_we = 1'b1;
      end else if (push) begin
        tos_next   = tos_reg + 1'b1;
        mem_we     = 1'b1;
        mem_waddr  = tos_reg + 1'b1;
        count_next = full ? count_reg : count_reg + 1'b1;
      end else if (pop && !empty) begin
        tos_next   = tos_reg - 1'b1;
        count_next = count_reg - 1'b1;
      end

      do_ckpt = ckpt && ckpt_ready;
      do_rel  = ckpt_release && (occ_reg != '0);
      if (do_ckpt) wr_next = wr_reg + 1'b1;
      if (do_rel)  rd_next = rd_reg + 1'b1;
      case ({do_ckpt, do_rel})
        2'b10:   occ_next = occ_reg + 1'b1;
        2'b01:   occ_next = occ_reg - 1'b1;
        default: occ_next = occ_reg;
      endcase
    end
  end

`ifdef RAS_CKPT_TOP_SAVE_EN
  // Top as it will read after this cycle's stack write lands.
  always_comb begin
    top_save = mem[tos_next];
    if (mem_we && (mem_waddr == tos_next)) top_save = mem_wdata;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos_reg   <= '1;
      count_reg <= '0;
      wr_reg    <= '0;
      rd_reg    <= '0;
      occ_reg   <= '0;
    end else begin
      tos_reg   <= tos_next;
      count_reg <= count_next;
      wr_reg    <= wr_next;
      rd_reg    <= rd_next;
      occ_reg   <= occ_next;
    end
  end

  // Storage arrays carry no reset; occupancy and count gate their validity.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (do_ckpt) begin
      slot_tos[wr_reg] <= tos_next;
      slot_cnt[wr_reg] <= count_next;
`ifdef RAS_CKPT_TOP_SAVE_EN
      slot_top[wr_reg] <= top_save;
`endif
    end
  end

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt: expectations queued at drive time, popped at sample time.
module tb_ras_ckpt;

  logic        clk, rst_n;
  logic        push, pop, ckpt, restore, rel;
  logic [31:0] din;
  logic [1:0]  restore_tag;
  logic [31:0] dout;
  logic        pop_valid, empty, full, ckpt_ready;
  logic [4:0]  count;
  logic [1:0]  ckpt_tag;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

`ifdef RAS_CKPT_TOP_SAVE_EN
  localparam logic [31:0] REPAIRED_TOP = 32'hB;
`else
  localparam logic [31:0] REPAIRED_TOP = 32'hE;
`endif

  ras_ckpt dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din),
    .dout(dout), .pop_valid(pop_valid), .empty(empty), .full(full),
    .count(count), .ckpt(ckpt), .ckpt_ready(ckpt_ready), .ckpt_tag(ckpt_tag),
    .restore(restore), .restore_tag(restore_tag), .ckpt_release(rel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      $error("FAIL sb_underflow: got 0x%0h expected no sample", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) begin
        passes++;
        $display("check %-16s got 0x%0h", e.name, obs);
      end else begin
        $error("FAIL %s: got 0x%0h expected 0x%0h", e.name, obs, e.val);
      end
    end
  endtask

  task automatic drive(input logic p, input logic po, input logic [31:0] d,
                       input logic c, input logic r, input logic [1:0] t, input logic rl);
    push = p; pop = po; din = d; ckpt = c; restore = r; restore_tag = t; rel = rl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    push = 0; pop = 0; din = 0; ckpt = 0; restore = 0; restore_tag = 0; rel = 0;
  endtask

  task automatic do_push(input logic [31:0] d);
    drive(1, 0, d, 0, 0, 2'd0, 0);
    tick();
  endtask

  initial begin
    logic [31:0] vals [3];
    vals[0] = 32'h300; vals[1] = 32'h200; vals[2] = 32'h100;

    rst_n = 1'b0;
    drive(0, 1, 0, 0, 0, 2'd0, 0);
    #1;
    expect_val("rst_empty", 1);      chk({31'd0, empty});
    expect_val("rst_full", 0);       chk({31'd0, full});
    expect_val("rst_count", 0);      chk({27'd0, count});
    expect_val("rst_ckpt_ready", 1); chk({31'd0, ckpt_ready});
    expect_val("rst_ckpt_tag", 0);   chk({30'd0, ckpt_tag});
    expect_val("rst_pop_valid", 0);  chk({31'd0, pop_valid});
    pop = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic LIFO order, then pop on empty.
    do_push(32'h100); do_push(32'h200); do_push(32'h300);
    expect_val("lifo_count", 3); chk({27'd0, count});
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0, 2'd0, 0);
      expect_val("lifo_dout", vals[i]); chk(dout);
      expect_val("lifo_pop_valid", 1);  chk({31'd0, pop_valid});
      tick();
    end
    drive(0, 1, 0, 0, 0, 2'd0, 0);
    expect_val("empty_pop_valid", 0); chk({31'd0, pop_valid});
    tick();
    expect_val("empty_pop_count", 0); chk({27'd0, count});

    // Overflow wraps, oldest entry lost.
    for (int i = 1; i <= 17; i++) do_push(32'(i));
    expect_val("ovf_full", 1);   chk({31'd0, full});
    expect_val("ovf_count", 16); chk({27'd0, count});
    for (int i = 17; i >= 2; i--) begin
      drive(0, 1, 0, 0, 0, 2'd0, 0);
      expect_val("ovf_dout", 32'(i)); chk(dout);
      tick();
    end
    drive(0, 1, 0, 0, 0, 2'd0, 0);
    expect_val("ovf_last_pop_valid", 0); chk({31'd0, pop_valid});
    tick();
    expect_val("ovf_empty", 1); chk({31'd0, empty});

    // Checkpoint then rollback after push/pop/pop.
    do_push(32'hA); do_push(32'hB);
    expect_val("ck_tag0", 0); chk({30'd0, ckpt_tag});
    drive(0, 0, 0, 1, 0, 2'd0, 0); tick();
    expect_val("ck_tag_adv", 1); chk({30'd0, ckpt_tag});
    do_push(32'hC);
    drive(0, 1, 0, 0, 0, 2'd0, 0); tick();
    drive(0, 1, 0, 0, 0, 2'd0, 0); tick();
    expect_val("spec_count", 1); chk({27'd0, count});
    expect_val("spec_dout", 32'hA); chk(dout);
    drive(0, 0, 0, 0, 1, 2'd0, 0); tick();
    expect_val("rb_count", 2);        chk({27'd0, count});
    expect_val("rb_dout", 32'hB);     chk(dout);
    expect_val("rb_ckpt_ready", 1);   chk({31'd0, ckpt_ready});
    expect_val("rb_ckpt_tag", 0);     chk({30'd0, ckpt_tag});

    // Top-entry repair after speculative replace.
    drive(0, 0, 0, 1, 0, 2'd0, 0); tick();
    drive(1, 1, 32'hE, 0, 0, 2'd0, 0); tick();
    expect_val("repl_dout", 32'hE); chk(dout);
    expect_val("repl_count", 2);    chk({27'd0, count});
    drive(0, 0, 0, 0, 1, 2'd0, 0); tick();
    expect_val("repair_dout", REPAIRED_TOP); chk(dout);
    expect_val("repair_count", 2);           chk({27'd0, count});

    // Checkpoint FIFO capacity, overflow ignore, release, ckpt+release.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0, 2'd0, 0); tick();
    end
    expect_val("fifo_full_ready", 0); chk({31'd0, ckpt_ready});
    expect_val("fifo_full_tag", 0);   chk({30'd0, ckpt_tag});
    drive(0, 0, 0, 1, 0, 2'd0, 0); tick();
    expect_val("fifo_ovf_tag", 0);   chk({30'd0, ckpt_tag});
    expect_val("fifo_ovf_ready", 0); chk({31'd0, ckpt_ready});
    drive(0, 0, 0, 0, 0, 2'd0, 1); tick();
    expect_val("rel_ready", 1); chk({31'd0, ckpt_ready});
    drive(0, 0, 0, 1, 0, 2'd0, 1); tick();
    expect_val("ckrel_ready", 1); chk({31'd0, ckpt_ready});
    expect_val("ckrel_tag", 1);   chk({30'd0, ckpt_tag});
    drive(0, 0, 0, 1, 0, 2'd0, 0); tick();
    expect_val("refill_ready", 0); chk({31'd0, ckpt_ready});
    expect_val("refill_tag", 2);   chk({30'd0, ckpt_tag});

    // Drain, then restore of an unallocated tag is fully ignored.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 2'd0, 1); tick();
    end
    drive(0, 0, 0, 1, 0, 2'd0, 0); tick();
    expect_val("pre_bad_tag", 3); chk({30'd0, ckpt_tag});
    drive(1, 0, 32'h55, 1, 1, 2'd3, 1); tick();
    expect_val("bad_count", 2);           chk({27'd0, count});
    expect_val("bad_dout", REPAIRED_TOP); chk(dout);
    expect_val("bad_tag", 3);             chk({30'd0, ckpt_tag});
    expect_val("bad_ready", 1);           chk({31'd0, ckpt_ready});
    drive(1, 0, 32'h55, 0, 1, 2'd2, 0); tick();
    expect_val("good_tag", 2);   chk({30'd0, ckpt_tag});
    expect_val("good_count", 2); chk({27'd0, count});

    // Asynchronous reset mid-sequence.
    do_push(32'h77);
    drive(0, 0, 0, 1, 0, 2'd0, 0); tick();
    expect_val("pre_rst_count", 3); chk({27'd0, count});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_val("arst_count", 0);    chk({27'd0, count});
    expect_val("arst_tag", 0);      chk({30'd0, ckpt_tag});
    expect_val("arst_empty", 1);    chk({31'd0, empty});
    expect_val("arst_ready", 1);    chk({31'd0, ckpt_ready});
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_push(32'h99);
    expect_val("post_rst_dout", 32'h99); chk(dout);
    expect_val("post_rst_count", 1);     chk({27'd0, count});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
